// File: rtl/opb_arb_pkg.sv
// opb_arb_pkg: shared FSM states, OPB widths and the round-robin pick helper.
package opb_arb_pkg;
    typedef enum logic [1:0] {IDLE, XFER, GAP, RESP} state_t;
    localparam int OPB_AW = 32;
    localparam int OPB_DW = 32;
    // One-hot grant of the first set request at or after ptr, wrapping within n lanes.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] g;
        logic [2:0] idx;
        g = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && req[idx]) g = 8'(1) << idx;
        end
        return g;
    endfunction
endpackage

// File: rtl/opb_reg_arbiter_if.sv
// opb_reg_arbiter_if: requester-side handshake plus OPB master/slave signals.
interface opb_reg_arbiter_if
    import opb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid, req_rnw, req_ready, rsp_valid;
    logic [OPB_AW*NUM_REQ-1:0] req_addr;
    logic [OPB_DW*NUM_REQ-1:0] req_wdata;
    logic [4*NUM_REQ-1:0]      req_be;
    logic [OPB_DW-1:0]         rsp_data;
    logic                      rsp_err;
    logic [0:OPB_AW-1]         M_ABus;
    logic [0:OPB_DW-1]         M_DBus, Sl_DBus;
    logic [0:3]                M_BE;
    logic                      M_RNW, M_select, M_seqAddr;
    logic                      Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    modport master (
        input  req_valid, req_rnw, req_addr, req_wdata, req_be,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output M_ABus, M_BE, M_DBus, M_RNW, M_select, M_seqAddr
    );
    modport slave (
        output req_valid, req_rnw, req_addr, req_wdata, req_be,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  M_ABus, M_BE, M_DBus, M_RNW, M_select, M_seqAddr
    );
endinterface

// File: rtl/opb_rr_arbiter.sv
// opb_rr_arbiter: combinational one-hot round-robin picker.
module opb_rr_arbiter
    import opb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);
    always_comb grant = NUM_REQ'(rr_pick(8'(req), 3'(ptr), NUM_REQ));
endmodule

// File: rtl/opb_reg_arbiter.sv
// opb_reg_arbiter: shares one OPB master port among NUM_REQ single-word requesters
// with round-robin grant, retry, error and timeout handling.
module opb_reg_arbiter
    import opb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int MAX_RETRY   = 3
) (
    input logic               OPB_Clk,
    input logic               OPB_Rst_n,
    opb_reg_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  pick, gnt;
    logic [PW-1:0]       rr_ptr, pick_idx, gnt_idx;
    logic [TW-1:0]       timer;
    logic [RW-1:0]       retry_cnt;
    logic [OPB_AW-1:0]   cmd_addr, cmd_addr_nxt;
    logic [OPB_DW-1:0]   cmd_wdata, cmd_wdata_nxt, fin_data;
    logic [3:0]          cmd_be, cmd_be_nxt;
    logic                cmd_rnw, cmd_rnw_nxt, accept, retry_go, fin_err, xfer_nxt;

    opb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(bus.req_valid), .ptr(rr_ptr), .grant(pick));

    always_comb begin
        pick_idx = '0;
        gnt_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    // Command is captured from the granted lane on accept and held through retries.
    always_comb begin
        accept        = state == IDLE && |bus.req_valid;
        cmd_addr_nxt  = accept ? bus.req_addr[OPB_AW*pick_idx +: OPB_AW] : cmd_addr;
        cmd_wdata_nxt = accept ? bus.req_wdata[OPB_DW*pick_idx +: OPB_DW] : cmd_wdata;
        cmd_be_nxt    = accept ? bus.req_be[4*pick_idx +: 4] : cmd_be;
        cmd_rnw_nxt   = accept ? bus.req_rnw[pick_idx] : cmd_rnw;
        xfer_nxt      = state_nxt == XFER;
        fin_data      = (bus.Sl_xferAck && !bus.Sl_errAck && cmd_rnw) ? bus.Sl_DBus : '0;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fin_err   = 1'b0;
        retry_go  = 1'b0;
        case (state)
            IDLE: state_nxt = |bus.req_valid ? XFER : IDLE;
            XFER:
                if (bus.Sl_errAck || bus.Sl_xferAck) begin
                    state_nxt = RESP;
                    fin_err   = bus.Sl_errAck;
                end else if (bus.Sl_retry) begin
                    retry_go  = retry_cnt < RW'(MAX_RETRY);
                    state_nxt = retry_go ? GAP : RESP;
                    fin_err   = !retry_go;
                end else if (timer == TW'(TIMEOUT_CYC - 1) && !bus.Sl_toutSup) begin
                    state_nxt = RESP;
                    fin_err   = 1'b1;
                end
            GAP: state_nxt = XFER;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = state == IDLE ? pick : '0;
        bus.rsp_valid = state == RESP ? gnt : '0;
        bus.M_seqAddr = 1'b0;
    end

    // OPB drive is registered and zeroed whenever select is low (OR-bus).
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            gnt          <= '0;
            rr_ptr       <= '0;
            timer        <= '0;
            retry_cnt    <= '0;
            cmd_addr     <= '0;
            cmd_wdata    <= '0;
            cmd_be       <= '0;
            cmd_rnw      <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
            bus.M_select <= 1'b0;
            bus.M_ABus   <= '0;
            bus.M_BE     <= '0;
            bus.M_DBus   <= '0;
            bus.M_RNW    <= 1'b0;
        end else begin
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            cmd_be    <= cmd_be_nxt;
            cmd_rnw   <= cmd_rnw_nxt;
            if (accept) begin
                gnt       <= pick;
                retry_cnt <= '0;
                timer     <= '0;
            end
            if (state == XFER) timer <= retry_go ? '0 : bus.Sl_toutSup ? timer : timer + 1'b1;
            if (retry_go) retry_cnt <= retry_cnt + 1'b1;
            if (state == XFER && state_nxt == RESP) begin
                bus.rsp_data <= fin_data;
                bus.rsp_err  <= fin_err;
            end
            if (state == RESP) rr_ptr <= gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            bus.M_select <= xfer_nxt;
            bus.M_ABus   <= xfer_nxt ? cmd_addr_nxt : '0;
            bus.M_BE     <= xfer_nxt ? cmd_be_nxt : '0;
            bus.M_DBus   <= xfer_nxt && !cmd_rnw_nxt ? cmd_wdata_nxt : '0;
            bus.M_RNW    <= xfer_nxt && cmd_rnw_nxt;
        end
    end
endmodule

// File: tb/tb_opb_reg_arbiter.sv
// tb_opb_reg_arbiter: directed bench with a response scoreboard and a scripted OPB slave.
module tb_opb_reg_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {int idx; logic [31:0] data; logic err;} exp_t;
    exp_t sb[$];
    exp_t cur;

    opb_reg_arbiter_if #(.NUM_REQ(2)) bus ();
    opb_reg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .bus(bus.master)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (|bus.rsp_valid) begin
            if (sb.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            else begin
                cur = sb.pop_front();
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(2'b01 << cur.idx));
                chk("rsp_data", 64'(bus.rsp_data), 64'(cur.data));
                chk("rsp_err", 64'(bus.rsp_err), 64'(cur.err));
            end
        end
    end

    task automatic wait_grant(input int i, output int n);
        n = 0;
        #1;
        while (!bus.req_ready[i] && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(2'b01 << i));
        tick();
    endtask

    task automatic issue(input int i, input bit rnw, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int n;
        bus.req_valid[i] = 1'b1;
        bus.req_rnw[i] = rnw;
        bus.req_addr[32*i +: 32] = a;
        bus.req_wdata[32*i +: 32] = wd;
        bus.req_be[4*i +: 4] = be;
        wait_grant(i, n);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic slave_clear();
        bus.Sl_xferAck = 1'b0;
        bus.Sl_errAck = 1'b0;
        bus.Sl_retry = 1'b0;
        bus.Sl_toutSup = 1'b0;
        bus.Sl_DBus = '0;
    endtask

    // Answers the current transfer: nretry retries, each after `delay` select cycles, then ack (or nothing).
    task automatic slave_run(input int nretry, input bit ack, input bit err_too, input logic [31:0] rdata,
                             input int delay, input int supp, output int sel, output int gap, output int cyc);
        int rc, inx;
        bit seen, done;
        rc = 0; inx = 0; seen = 0; done = 0; sel = 0; gap = 0; cyc = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            slave_clear();
            if (bus.M_select) begin
                seen = 1; sel++; inx++;
                bus.Sl_toutSup = sel <= supp;
                if (inx == delay) begin
                    if (rc < nretry) begin
                        bus.Sl_retry = 1'b1; rc++; inx = 0;
                    end else if (ack) begin
                        bus.Sl_xferAck = 1'b1; bus.Sl_errAck = err_too; bus.Sl_DBus = rdata;
                    end
                end
            end else if (seen && |bus.rsp_valid) done = 1;
            else if (seen) gap++;
            if (!done) begin
                tick();
                cyc++;
            end
        end
        slave_clear();
        chk("xfer_done", 64'(done), 64'd1);
    endtask

    initial begin
        int sel, gap, cyc, n;
        bus.req_valid = '0; bus.req_rnw = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
        slave_clear();
        tick(); tick();
        chk("rst_select", 64'(bus.M_select), 64'd0);
        chk("rst_abus", 64'(bus.M_ABus), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'({bus.rsp_err, bus.rsp_data}), 64'd0);
        rst_n = 1'b1;
        tick();

        // single read, ack on the 2nd select cycle
        issue(0, 1'b1, 32'h0100_4700, 32'h0, 4'hF);
        chk("rd_select", 64'(bus.M_select), 64'd1);
        chk("rd_abus", 64'(bus.M_ABus), 64'h0100_4700);
        chk("rd_rnw", 64'(bus.M_RNW), 64'd1);
        chk("rd_dbus", 64'(bus.M_DBus), 64'd0);
        chk("rd_be", 64'(bus.M_BE), 64'hF);
        sb.push_back('{0, 32'hC09F_1201, 1'b0});
        slave_run(0, 1, 0, 32'hC09F_1201, 2, 0, sel, gap, cyc);
        chk("rd_sel_cycles", 64'(sel), 64'd2);
        chk("rd_latency", 64'(cyc), 64'd2);

        // single write from requester 1: write response data is 0 even if the slave drives DBus
        issue(1, 1'b0, 32'h0100_4704, 32'hDEAD_BEEF, 4'b0011);
        chk("wr_dbus", 64'(bus.M_DBus), 64'hDEAD_BEEF);
        chk("wr_rnw", 64'(bus.M_RNW), 64'd0);
        chk("wr_be", 64'(bus.M_BE), 64'h3);
        sb.push_back('{1, 32'h0, 1'b0});
        slave_run(0, 1, 0, 32'hFFFF_FFFF, 1, 0, sel, gap, cyc);

        // contention: both requesters continuously valid, grants alternate
        bus.req_rnw = 2'b01;
        bus.req_addr = {32'h0100_470C, 32'h0100_4708};
        bus.req_wdata = {32'h1234_5678, 32'h0};
        bus.req_be = 8'hFF;
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            int g;
            g = t % 2;
            wait_grant(g, n);
            if (t > 0) chk("turnaround", 64'(n), 64'd1);
            chk("ct_rnw", 64'(bus.M_RNW), 64'(g == 0));
            chk("ct_dbus", 64'(bus.M_DBus), g == 1 ? 64'h1234_5678 : 64'd0);
            sb.push_back('{g, g == 0 ? 32'hA5A5_0000 | t : 32'h0, 1'b0});
            slave_run(0, 1, 0, 32'hA5A5_0000 | t, 1, 0, sel, gap, cyc);
        end
        bus.req_valid = '0;
        tick();

        // three retries then ack
        issue(0, 1'b1, 32'h0100_4710, 32'h0, 4'hF);
        sb.push_back('{0, 32'h0BAD_F00D, 1'b0});
        slave_run(3, 1, 0, 32'h0BAD_F00D, 1, 0, sel, gap, cyc);
        chk("retry3_sel", 64'(sel), 64'd4);
        chk("retry3_gap", 64'(gap), 64'd3);

        // four retries: failed, no fifth select
        issue(0, 1'b1, 32'h0100_4710, 32'h0, 4'hF);
        sb.push_back('{0, 32'h0, 1'b1});
        slave_run(4, 1, 0, 32'h0BAD_F00D, 1, 0, sel, gap, cyc);
        chk("retry4_sel", 64'(sel), 64'd4);
        chk("retry4_gap", 64'(gap), 64'd3);

        // timeout with no slave answer
        issue(1, 1'b1, 32'h0200_0000, 32'h0, 4'hF);
        sb.push_back('{1, 32'h0, 1'b1});
        slave_run(0, 0, 0, 32'h0, 1, 0, sel, gap, cyc);
        chk("tout_sel", 64'(sel), 64'd16);

        // timeout extended by 10 cycles of toutSup
        issue(1, 1'b0, 32'h0200_0000, 32'h5555_AAAA, 4'hF);
        sb.push_back('{1, 32'h0, 1'b1});
        slave_run(0, 0, 0, 32'h0, 1, 10, sel, gap, cyc);
        chk("toutsup_sel", 64'(sel), 64'd26);

        // errAck wins over a simultaneous xferAck
        issue(0, 1'b1, 32'h0100_4700, 32'h0, 4'hF);
        sb.push_back('{0, 32'h0, 1'b1});
        slave_run(0, 1, 1, 32'h1357_9BDF, 1, 0, sel, gap, cyc);

        // reset mid-transfer: rr_ptr is 1 here, so a surviving pointer would grant requester 1
        issue(1, 1'b1, 32'h0100_4704, 32'h0, 4'hF);
        chk("mid_select", 64'(bus.M_select), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_select", 64'(bus.M_select), 64'd0);
        chk("arst_abus", 64'(bus.M_ABus), 64'd0);
        chk("arst_rnw", 64'(bus.M_RNW), 64'd0);
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        bus.req_rnw = 2'b11;
        bus.req_addr = {32'h0100_4704, 32'h0100_4700};
        bus.req_valid = 2'b11;
        wait_grant(0, n);
        bus.req_valid = '0;
        sb.push_back('{0, 32'h2468_ACE0, 1'b0});
        slave_run(0, 1, 0, 32'h2468_ACE0, 1, 0, sel, gap, cyc);
        tick(); tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
